// File: rtl/mem_access_ctrl_if.sv
// Handshake/strobe bundle between the CPU control FSM, the MDR and SRAM.
// MEM_STATS_EN adds the Rd_Count/Wr_Count statistics outputs.
interface mem_access_ctrl_if;
  logic Rd_Req;
  logic Wr_Req;
  logic Mem_Stall;
  logic MIO_EN;
  logic LD_MDR;
  logic Mem_OE_n;
  logic Mem_WE_n;
  logic Busy;
  logic Done;
`ifdef MEM_STATS_EN
  logic [15:0] Rd_Count;
  logic [15:0] Wr_Count;
`endif

  modport master (
    output Rd_Req, Wr_Req, Mem_Stall,
    input  MIO_EN, LD_MDR, Mem_OE_n, Mem_WE_n, Busy, Done
`ifdef MEM_STATS_EN
    , input Rd_Count, Wr_Count
`endif
  );

  modport slave (
    input  Rd_Req, Wr_Req, Mem_Stall,
    output MIO_EN, LD_MDR, Mem_OE_n, Mem_WE_n, Busy, Done
`ifdef MEM_STATS_EN
    , output Rd_Count, Wr_Count
`endif
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// One-transaction-at-a-time memory sequencer for the SLC-3 MDR/SRAM path.
// Optional MEM_STATS_EN macro adds completed read/write counters.
module mem_access_ctrl #(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned READ_WAIT  = 1,
  parameter int unsigned WRITE_WAIT = 1
) (
  input logic              Clk,
  input logic              Reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_WAIT  = 3'd1,
    S_RD_LATCH = 3'd2,
    S_WR_WAIT  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             mio_next, ld_next, oe_n_next, we_n_next, busy_next, done_next;

  // State, counter and outputs; outputs are registered from the next-state decode
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bus.MIO_EN   <= 1'b0;
      bus.LD_MDR   <= 1'b0;
      bus.Mem_OE_n <= 1'b1;
      bus.Mem_WE_n <= 1'b1;
      bus.Busy     <= 1'b0;
      bus.Done     <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      bus.MIO_EN   <= mio_next;
      bus.LD_MDR   <= ld_next;
      bus.Mem_OE_n <= oe_n_next;
      bus.Mem_WE_n <= we_n_next;
      bus.Busy     <= busy_next;
      bus.Done     <= done_next;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.Rd_Req) begin
          state_next = S_RD_WAIT;
          cnt_next   = CNT_W'(READ_WAIT);
        end else if (bus.Wr_Req) begin
          state_next = S_WR_WAIT;
          cnt_next   = CNT_W'(WRITE_WAIT);
        end
      end
      S_RD_WAIT: begin
        if (!bus.Mem_Stall) begin
          if (cnt != '0) cnt_next = cnt - CNT_W'(1);
          else           state_next = S_RD_LATCH;
        end
      end
      S_RD_LATCH: state_next = S_DONE;
      S_WR_WAIT: begin
        if (!bus.Mem_Stall) begin
          if (cnt != '0) cnt_next = cnt - CNT_W'(1);
          else           state_next = S_DONE;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Moore output decode of the state about to be registered
  always_comb begin
    mio_next  = 1'b0;
    ld_next   = 1'b0;
    oe_n_next = 1'b1;
    we_n_next = 1'b1;
    busy_next = 1'b0;
    done_next = 1'b0;
    case (state_next)
      S_RD_WAIT: begin
        mio_next  = 1'b1;
        oe_n_next = 1'b0;
        busy_next = 1'b1;
      end
      S_RD_LATCH: begin
        mio_next  = 1'b1;
        ld_next   = 1'b1;
        oe_n_next = 1'b0;
        busy_next = 1'b1;
      end
      S_WR_WAIT: begin
        we_n_next = 1'b0;
        busy_next = 1'b1;
      end
      S_DONE:  done_next = 1'b1;
      default: ;
    endcase
  end

`ifdef MEM_STATS_EN
  logic last_rd;

  // Count only transactions that actually reach DONE
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_rd      <= 1'b0;
      bus.Rd_Count <= '0;
      bus.Wr_Count <= '0;
    end else begin
      if (state == S_IDLE && state_next == S_RD_WAIT) last_rd <= 1'b1;
      else if (state == S_IDLE && state_next == S_WR_WAIT) last_rd <= 1'b0;
      if (state == S_DONE) begin
        if (last_rd) bus.Rd_Count <= bus.Rd_Count + 16'd1;
        else         bus.Wr_Count <= bus.Wr_Count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset abort
// sequence and randomized transactions against a transaction-level model.
module tb_mem_access_ctrl;
  localparam int unsigned READ_WAIT  = 1;
  localparam int unsigned WRITE_WAIT = 1;

  // {MIO_EN, LD_MDR, Mem_OE_n, Mem_WE_n, Busy, Done}
  typedef struct packed {
    logic mio;
    logic ld;
    logic oe_n;
    logic we_n;
    logic busy;
    logic done;
  } out_t;

  localparam out_t O_IDLE = 6'b001100;
  localparam out_t O_RDW  = 6'b100110;
  localparam out_t O_LAT  = 6'b110110;
  localparam out_t O_WRW  = 6'b001010;
  localparam out_t O_DONE = 6'b001101;

  typedef struct {
    logic  rd;
    logic  wr;
    logic  stall;
    out_t  exp;
    string name;
  } vec_t;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_pass;
  int   exp_rd;
  int   exp_wr;
  vec_t vt[$];

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(
    .CNT_W     (4),
    .READ_WAIT (READ_WAIT),
    .WRITE_WAIT(WRITE_WAIT)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_out(input out_t exp, input string name);
    out_t got;
    got = {bus.MIO_EN, bus.LD_MDR, bus.Mem_OE_n, bus.Mem_WE_n, bus.Busy, bus.Done};
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: mio/ld/oe_n/we_n/busy/done got %b required %b at %0t",
                  name, got, exp, $time);
  endtask

  // Apply inputs for the coming edge, then check the cycle that follows it
  task automatic step(input logic rd, input logic wr, input logic stall,
                      input out_t exp, input string name);
    bus.Rd_Req    = rd;
    bus.Wr_Req    = wr;
    bus.Mem_Stall = stall;
    @(posedge Clk);
    #1;
    check_out(exp, name);
  endtask

  task automatic add_vec(input logic rd, input logic wr, input logic stall,
                         input out_t exp, input string name);
    vec_t v;
    v.rd = rd; v.wr = wr; v.stall = stall; v.exp = exp; v.name = name;
    vt.push_back(v);
  endtask

  function automatic logic rbit();
    return 1'($urandom % 2);
  endfunction

  initial begin
    int   gap, kind, need, served;
    logic is_rd, s;

    n_checks = 0;
    n_pass   = 0;
    exp_rd   = 0;
    exp_wr   = 0;
    Reset         = 1'b1;
    bus.Rd_Req    = 1'b0;
    bus.Wr_Req    = 1'b0;
    bus.Mem_Stall = 1'b0;
    #1;
    check_out(O_IDLE, "reset_state");
`ifdef MEM_STATS_EN
    n_checks++;
    if (bus.Rd_Count == 16'd0 && bus.Wr_Count == 16'd0) n_pass++;
    else $display("FAIL reset_counts: got %h/%h required 0000/0000", bus.Rd_Count, bus.Wr_Count);
`endif
    @(posedge Clk);
    #1;
    check_out(O_IDLE, "reset_held");
    #2 Reset = 1'b0;

    // Plain read: OE low cycles 1-3, LD_MDR cycle 3, Done cycle 4
    add_vec(1, 0, 0, O_RDW,  "rd_c1");
    add_vec(0, 0, 0, O_RDW,  "rd_c2");
    add_vec(0, 0, 0, O_LAT,  "rd_c3");
    add_vec(1, 1, 0, O_DONE, "rd_c4");
    add_vec(0, 0, 0, O_IDLE, "rd_c5");
    // Plain write: WE low cycles 1-2, Done cycle 3
    add_vec(0, 1, 0, O_WRW,  "wr_c1");
    add_vec(0, 0, 0, O_WRW,  "wr_c2");
    add_vec(0, 0, 0, O_DONE, "wr_c3");
    add_vec(0, 0, 0, O_IDLE, "wr_c4");
    // Read stalled in cycles 1-3: LD_MDR cycle 6, Done cycle 7
    add_vec(1, 0, 0, O_RDW,  "st_c1");
    add_vec(0, 0, 1, O_RDW,  "st_c2");
    add_vec(0, 0, 1, O_RDW,  "st_c3");
    add_vec(0, 0, 1, O_RDW,  "st_c4");
    add_vec(0, 0, 0, O_RDW,  "st_c5");
    add_vec(0, 0, 0, O_LAT,  "st_c6");
    add_vec(0, 0, 1, O_DONE, "st_c7");
    add_vec(0, 0, 0, O_IDLE, "st_c8");
    // Simultaneous requests: read wins, write dropped
    add_vec(1, 1, 0, O_RDW,  "both_c1");
    add_vec(0, 0, 0, O_RDW,  "both_c2");
    add_vec(0, 0, 0, O_LAT,  "both_c3");
    add_vec(0, 0, 0, O_DONE, "both_c4");
    add_vec(0, 0, 0, O_IDLE, "both_c5");
    add_vec(0, 0, 0, O_IDLE, "both_c6");

    foreach (vt[i]) step(vt[i].rd, vt[i].wr, vt[i].stall, vt[i].exp, vt[i].name);
    exp_rd += 3;
    exp_wr += 1;

    // Reset mid-RD_WAIT between edges: outputs drop at once, no Done, restart works
    step(1, 0, 0, O_RDW, "abort_start");
    #3 Reset = 1'b1;
    #1 check_out(O_IDLE, "abort_async");
    bus.Rd_Req = 1'b0;
    @(posedge Clk);
    #1 check_out(O_IDLE, "abort_held");
    #2 Reset = 1'b0;
    step(0, 0, 0, O_IDLE, "abort_no_done1");
    step(0, 0, 0, O_IDLE, "abort_no_done2");
    step(1, 0, 0, O_RDW,  "after_c1");
    step(0, 0, 0, O_RDW,  "after_c2");
    step(0, 0, 0, O_LAT,  "after_c3");
    step(0, 0, 0, O_DONE, "after_c4");
    step(0, 0, 0, O_IDLE, "after_c5");
    exp_rd += 1;

    // Random transactions: each needs (wait+1) unstalled wait cycles
    for (int t = 0; t < 300; t++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step(0, 0, rbit(), O_IDLE, "rnd_idle");
      kind  = $urandom_range(0, 2);
      is_rd = (kind != 1);
      step(is_rd, kind != 0, rbit(), is_rd ? O_RDW : O_WRW, "rnd_start");
      need   = int'(is_rd ? READ_WAIT : WRITE_WAIT) + 1;
      served = 0;
      while (served < need) begin
        s = (($urandom % 3) == 0);
        if (!s) served++;
        step(rbit(), rbit(), s,
             (served == need) ? (is_rd ? O_LAT : O_DONE) : (is_rd ? O_RDW : O_WRW),
             "rnd_wait");
      end
      if (is_rd) step(rbit(), rbit(), rbit(), O_DONE, "rnd_latch");
      step(rbit(), rbit(), rbit(), O_IDLE, "rnd_done");
      if (is_rd) exp_rd++;
      else       exp_wr++;
    end

`ifdef MEM_STATS_EN
    n_checks++;
    if (bus.Rd_Count == 16'(exp_rd)) n_pass++;
    else $display("FAIL rd_count: got %0d required %0d", bus.Rd_Count, exp_rd);
    n_checks++;
    if (bus.Wr_Count == 16'(exp_wr)) n_pass++;
    else $display("FAIL wr_count: got %0d required %0d", bus.Wr_Count, exp_wr);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
